// File: rtl/period_meter_pkg.sv
// Shared types for the period meter: FSM state encoding.
package period_meter_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus rising-edge strobe for an asynchronous input.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic rise
);

   logic sync_p0, sync_p1, prev_p2;
   logic vld_p0, vld_p1;
   logic armed;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         prev_p2 <= 1'b0;
         vld_p0  <= 1'b0;
         vld_p1  <= 1'b0;
         armed   <= 1'b0;
      end else begin
         // stage 0/1: metastability filter; stage 2: previous sample for edge detect
         sync_p0 <= sig_in;
         sync_p1 <= sync_p0;
         prev_p2 <= sync_p1;
         vld_p0  <= 1'b1;
         vld_p1  <= vld_p0;
         // Arm only after a genuinely synchronized low, so a level that is
         // already high at reset release never looks like an edge.
         if (vld_p1 && !sync_p1)
            armed <= 1'b1;
      end
   end

   assign rise = armed & sync_p1 & ~prev_p2;

endmodule

// File: rtl/period_meter.sv
// Measures the clk-cycle period between rising edges of sig_in and hands
// each result out on a valid/ready interface, flagging timeouts and drops.
module period_meter
   import period_meter_pkg::*;
#(
   parameter  int MAX_COUNT = 27_000_000,
   localparam int W         = $clog2(MAX_COUNT + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         sig_in,
   output logic [W-1:0] period,
   output logic         period_valid,
   input  logic         period_ready,
   output logic         timeout,
   output logic         overrun,
   output logic         active
);

   localparam logic [W-1:0] MAX_CNT = W'(MAX_COUNT);

   state_t       state;
   logic [W-1:0] count;
   logic         rise;
   logic         meas_vld;

   // Counter never wraps: it pins at MAX_CNT even if the FSM were to stall there.
   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
      return (v >= MAX_CNT) ? MAX_CNT : v + W'(1);
   endfunction

   sync_edge u_sync_edge (
      .clk    (clk),
      .rst    (rst),
      .sig_in (sig_in),
      .rise   (rise)
   );

   assign meas_vld = rise && (state == MEASURE);
   assign active   = (state == MEASURE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         count        <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         timeout      <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         timeout <= 1'b0;
         overrun <= 1'b0;

         case (state)
            IDLE: begin
               if (rise) begin
                  state <= MEASURE;
                  count <= W'(1);
               end else begin
                  count <= '0;
               end
            end
            MEASURE: begin
               // A rise on the MAX_CNT cycle is still a valid measurement.
               if (rise) begin
                  count <= W'(1);
               end else if (count == MAX_CNT) begin
                  state   <= IDLE;
                  count   <= '0;
                  timeout <= 1'b1;
               end else begin
                  count <= sat_inc(count);
               end
            end
         endcase

         // A result held under backpressure is never overwritten.
         if (meas_vld) begin
            if (!period_valid || period_ready) begin
               period       <= count;
               period_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (period_valid && period_ready) begin
            period_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with MAX_COUNT=100.
module tb_period_meter;

   localparam int MAX_COUNT = 100;
   localparam int W         = $clog2(MAX_COUNT + 1);
   // sig_in edge to registered output: 2 sync flops + 1 output register
   localparam int LAT       = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sig_in = 1'b0;
   logic         period_ready = 1'b0;
   logic [W-1:0] period;
   logic         period_valid;
   logic         timeout;
   logic         overrun;
   logic         active;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int to_cnt = 0;
   int ov_cnt = 0;
   int hs_cnt = 0;
   int exp_hs = 0;

   logic         stall_prev = 1'b0;
   logic [W-1:0] held = '0;

   always #5 clk = ~clk;

   period_meter #(.MAX_COUNT(MAX_COUNT)) dut (
      .clk          (clk),
      .rst          (rst),
      .sig_in       (sig_in),
      .period       (period),
      .period_valid (period_valid),
      .period_ready (period_ready),
      .timeout      (timeout),
      .overrun      (overrun),
      .active       (active)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // One full period p of sig_in, starting with the rising edge now.
   task automatic wave(input int p);
      sig_in = 1'b1;
      repeat (p / 2) tick();
      sig_in = 1'b0;
      repeat (p - p / 2) tick();
   endtask

   task automatic clear_counts();
      to_cnt = 0;
      ov_cnt = 0;
      hs_cnt = 0;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      sig_in = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      repeat (3) tick();
      clear_counts();
   endtask

   // Negedge monitor: event counts, handshake values, and hold-under-stall.
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (timeout) to_cnt++;
         if (overrun) ov_cnt++;
         if (stall_prev)
            check("hold", 32'({period_valid, period}), 32'({1'b1, held}));
         if (period_valid && period_ready) begin
            hs_cnt++;
            check("hs_period", 32'(period), 32'(exp_hs));
         end
         stall_prev = period_valid && !period_ready;
         held       = period;
      end
   end

   initial begin
      int t0;
      int seen;

      // Reset with sig_in toggling: everything quiet during and just after.
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sig_in = ~sig_in;
         tick();
         check("rst_outs", 32'({period, period_valid, timeout, overrun, active}), 0);
      end
      rst    = 1'b0;
      sig_in = ~sig_in;
      tick();
      check("post_rst_outs", 32'({period, period_valid, timeout, overrun, active}), 0);

      // sig_in high across reset release must not count as an edge.
      rst    = 1'b1;
      sig_in = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (20) tick();
      check("high_at_release", 32'(active), 0);
      sig_in = 1'b0;
      repeat (5) tick();
      wave(10);
      check("edge_after_low", 32'(active), 1);

      // Period 10, ready high.
      do_reset();
      period_ready = 1'b1;
      exp_hs       = 10;
      wave(10);
      check("p10_no_valid_1st", 32'(period_valid), 0);
      check("p10_active", 32'(active), 1);
      repeat (5) wave(10);
      check("p10_results", 32'(hs_cnt), 5);
      check("p10_overrun", 32'(ov_cnt), 0);
      check("p10_timeout", 32'(to_cnt), 0);

      // Period 10 with backpressure, then release.
      do_reset();
      period_ready = 1'b0;
      exp_hs       = 10;
      repeat (4) wave(10);
      check("bp_valid", 32'(period_valid), 1);
      check("bp_period", 32'(period), 10);
      check("bp_overruns", 32'(ov_cnt), 2);
      period_ready = 1'b1;
      repeat (3) wave(10);
      check("bp_results", 32'(hs_cnt), 4);
      check("bp_overruns_end", 32'(ov_cnt), 2);

      // Single edge then silence: timeout MAX_COUNT cycles later.
      do_reset();
      period_ready = 1'b1;
      t0     = cyc;
      seen   = -1;
      sig_in = 1'b1;
      repeat (5) tick();
      sig_in = 1'b0;
      for (int i = 0; i < 150; i++) begin
         tick();
         if (timeout && seen < 0) seen = cyc;
      end
      check("to_latency", 32'(seen - t0), 32'(MAX_COUNT + LAT));
      check("to_pulses", 32'(to_cnt), 1);
      check("to_active", 32'(active), 0);
      check("to_valid", 32'(period_valid), 0);
      wave(10);
      repeat (10) tick();
      check("to_lone_edge_hs", 32'(hs_cnt), 0);
      check("to_lone_edge_valid", 32'(period_valid), 0);
      check("to_lone_edge_active", 32'(active), 1);

      // Edges exactly MAX_COUNT apart: reported, no timeout.
      do_reset();
      period_ready = 1'b1;
      exp_hs       = 100;
      wave(100);
      sig_in = 1'b1;
      repeat (5) tick();
      sig_in = 1'b0;
      repeat (10) tick();
      check("max_hs", 32'(hs_cnt), 1);
      check("max_period", 32'(period), 100);
      check("max_no_timeout", 32'(to_cnt), 0);

      // Edges MAX_COUNT+1 apart: timeout, no result.
      do_reset();
      wave(101);
      wave(10);
      check("over_timeout", 32'(to_cnt), 1);
      check("over_hs", 32'(hs_cnt), 0);
      check("over_active", 32'(active), 1);

      // Reset mid-measurement with a result pending.
      do_reset();
      period_ready = 1'b0;
      exp_hs       = 20;
      wave(20);
      wave(20);
      repeat (32) tick();
      check("midrst_pending", 32'(period_valid), 1);
      rst = 1'b1;
      tick();
      check("midrst_valid", 32'(period_valid), 0);
      check("midrst_active", 32'(active), 0);
      rst          = 1'b0;
      period_ready = 1'b1;
      repeat (3) tick();
      clear_counts();
      wave(20);
      check("midrst_1st_edge", 32'(period_valid), 0);
      wave(20);
      wave(20);
      check("midrst_results", 32'(hs_cnt), 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
